// File: rtl/pixel_map_param.sv
// pixel_map_param: inverse-perspective pixel remapper.
// For every destination pixel (x,y) in raster order it evaluates
//   qx = (p1*x + p2*y + p3) / (p7*x + p8*y + p9)
//   qy = (p4*x + p5*y + p6) / (p7*x + p8*y + p9)
// using incremental accumulators and two sequential dividers (one per lane).
// It then fetches source[qx,qy] or substitutes black/border/clamped data.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_start         one-cycle request to map a frame (ignored while busy)
//   p1..p9              signed coefficients, latched at frame_start
//   oob_mode            0 black, 1 border, 2 clamp, 3 same as 0
//   border_pix          colour for oob_mode=1
//   pixel_in/src_addr   source-buffer read port; src_addr is held for MEM_LAT
//                       cycles and pixel_in is sampled on the last of them
//   pixel_out/dst_addr/dst_wr  destination write port, one strobe per pixel
//   busy, frame_done    frame status; frame_done pulses after the last write

module pmp_div #(
  parameter int W = 79
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] q_o,
  output logic         rdy_o
);
  localparam int CW = $clog2(W + 1);

  // Restoring divider on magnitudes; sign applied at the output so the
  // quotient truncates toward zero.
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic          neg_q, run_q, rdy_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    sh, diff;

  assign sh   = {rem_q, quo_q[W-1]};
  assign diff = sh - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0; quo_q <= '0; dvs_q <= '0;
      neg_q <= 1'b0; run_q <= 1'b0; rdy_q <= 1'b0; cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dvd_i[W-1] ? -dvd_i : dvd_i;
      dvs_q <= dvs_i[W-1] ? -dvs_i : dvs_i;
      neg_q <= dvd_i[W-1] ^ dvs_i[W-1];
      run_q <= 1'b1;
      rdy_q <= 1'b0;
      cnt_q <= CW'(W);
    end else if (run_q) begin
      if (diff[W]) begin
        rem_q <= sh[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end else begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q <= 1'b0;
        rdy_q <= 1'b1;
      end
    end
  end

  assign q_o   = neg_q ? -quo_q : quo_q;
  assign rdy_o = rdy_q;
endmodule

module pixel_map_param #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 12,
  parameter int ACC_W    = 79,
  parameter int ADDR_W   = 17,
  parameter int SCALE_SH = 1,
  parameter int MEM_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic signed [ACC_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9,
  input  logic [1:0]              oob_mode,
  input  logic [PIX_W-1:0]        border_pix,
  input  logic [PIX_W-1:0]        pixel_in,
  output logic [ADDR_W-1:0]       src_addr,
  output logic [PIX_W-1:0]        pixel_out,
  output logic [ADDR_W-1:0]       dst_addr,
  output logic                    dst_wr,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0]    XMAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]    YMAX = YW'(V_ACTIVE - 1);
  localparam logic [ACC_W-1:0] HMAX = ACC_W'(H_ACTIVE - 1);
  localparam logic [ACC_W-1:0] VMAX = ACC_W'(V_ACTIVE - 1);
  localparam int LANES = 2;   // lane 0 = x quotient, lane 1 = y quotient

  typedef enum logic [2:0] {IDLE, DIV, MEMW, WR, NEXT} state_e;

  state_e                      state_q;
  logic [5:0][ACC_W-1:0]       inc_q;   // {p8,p7,p5,p4,p2,p1}; p3/p6/p9 only seed the accumulators
  logic [ACC_W-1:0]            nx_q, ny_q, dn_q, rx_q, ry_q, rd_q;
  logic [XW-1:0]               x_q;
  logic [YW-1:0]               y_q;
  logic [1:0]                  mode_q;
  logic [PIX_W-1:0]            bpix_q, pout_q;
  logic [ADDR_W-1:0]           saddr_q, daddr_q;
  logic [2:0]                  mcnt_q;
  logic                        busy_q, done_q, wr_q, pend_q;

  logic [LANES-1:0][ACC_W-1:0] dvd, quo;
  logic [LANES-1:0]            rdy;
  logic                        div_start, den_z, resolve, in_rng, rd_src;
  logic [ACC_W-1:0]            qx, qy, cx, cy;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] sa, sb;
    sa = a >> SCALE_SH;
    sb = b >> SCALE_SH;
    return ADDR_W'(sb) * ADDR_W'(H_ACTIVE >> SCALE_SH) + ADDR_W'(sa);
  endfunction

  assign dvd = {ny_q, nx_q};

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      pmp_div #(.W(ACC_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .dvd_i   (dvd[l]),
        .dvs_i   (dn_q),
        .q_o     (quo[l]),
        .rdy_o   (rdy[l])
      );
    end
  endgenerate

  // pend_q marks that the dividers were kicked for this pixel, so a stale
  // ready from the previous pixel is never mistaken for a fresh result.
  assign den_z     = (dn_q == '0);
  assign div_start = (state_q == DIV) && !pend_q && !den_z;
  assign resolve   = (state_q == DIV) && (den_z || (pend_q && (&rdy)));

  assign qx     = den_z ? '0 : quo[0];
  assign qy     = den_z ? '0 : quo[1];
  assign in_rng = !den_z && !qx[ACC_W-1] && (qx <= HMAX) && !qy[ACC_W-1] && (qy <= VMAX);
  assign cx     = qx[ACC_W-1] ? '0 : ((qx > HMAX) ? HMAX : qx);
  assign cy     = qy[ACC_W-1] ? '0 : ((qy > VMAX) ? VMAX : qy);
  assign rd_src = in_rng || (mode_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inc_q   <= '0;
      nx_q <= '0; ny_q <= '0; dn_q <= '0; rx_q <= '0; ry_q <= '0; rd_q <= '0;
      x_q <= '0; y_q <= '0;
      mode_q <= '0; bpix_q <= '0; pout_q <= '0;
      saddr_q <= '0; daddr_q <= '0; mcnt_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; wr_q <= 1'b0; pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_start) begin
          inc_q  <= {p8, p7, p5, p4, p2, p1};
          mode_q <= (oob_mode == 2'd3) ? 2'd0 : oob_mode;
          bpix_q <= border_pix;
          x_q <= '0; y_q <= '0;
          nx_q <= p3; rx_q <= p3;
          ny_q <= p6; ry_q <= p6;
          dn_q <= p9; rd_q <= p9;
          busy_q  <= 1'b1;
          pend_q  <= 1'b0;
          state_q <= DIV;
        end
        DIV: begin
          if (div_start) pend_q <= 1'b1;
          if (resolve) begin
            pend_q  <= 1'b0;
            daddr_q <= pix_addr(ACC_W'(x_q), ACC_W'(y_q));
            if (rd_src) begin
              saddr_q <= pix_addr(cx, cy);
              mcnt_q  <= 3'(MEM_LAT - 1);
              state_q <= MEMW;
            end else begin
              pout_q  <= (mode_q == 2'd1) ? bpix_q : '0;
              wr_q    <= 1'b1;
              state_q <= WR;
            end
          end
        end
        MEMW: begin
          if (mcnt_q == 3'd0) begin
            pout_q  <= pixel_in;
            wr_q    <= 1'b1;
            state_q <= WR;
          end else begin
            mcnt_q <= mcnt_q - 3'd1;
          end
        end
        WR: begin
          wr_q    <= 1'b0;
          state_q <= NEXT;
        end
        NEXT: begin
          if (x_q != XMAX) begin
            x_q  <= x_q + XW'(1);
            nx_q <= nx_q + inc_q[0];
            ny_q <= ny_q + inc_q[2];
            dn_q <= dn_q + inc_q[4];
            state_q <= DIV;
          end else if (y_q != YMAX) begin
            // Restart each row from exact row accumulators.
            x_q  <= '0;
            y_q  <= y_q + YW'(1);
            rx_q <= rx_q + inc_q[1]; nx_q <= rx_q + inc_q[1];
            ry_q <= ry_q + inc_q[3]; ny_q <= ry_q + inc_q[3];
            rd_q <= rd_q + inc_q[5]; dn_q <= rd_q + inc_q[5];
            state_q <= DIV;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_addr   = saddr_q;
  assign dst_addr   = daddr_q;
  assign pixel_out  = pout_q;
  assign dst_wr     = wr_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_pixel_map_param.sv
// Bench for pixel_map_param: 8x4 frame, no subsampling, 2-cycle source read.
// Expected writes come from a closed-form projective model evaluated per pixel.
module tb_pixel_map_param;
  localparam int H = 8, V = 4, PW = 12, AW = 79, ADW = 17, SH = 0, LAT = 2;
  localparam int NPIX = H * V;

  logic                 clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic signed [AW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [1:0]           oob_mode;
  logic [PW-1:0]        border_pix, pixel_in, pixel_out;
  logic [ADW-1:0]       src_addr, dst_addr;
  logic                 dst_wr, busy, frame_done;

  always #5 clk = ~clk;

  pixel_map_param #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .ACC_W(AW), .ADDR_W(ADW),
                    .SCALE_SH(SH), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .oob_mode(oob_mode), .border_pix(border_pix), .pixel_in(pixel_in),
    .src_addr(src_addr), .pixel_out(pixel_out), .dst_addr(dst_addr),
    .dst_wr(dst_wr), .busy(busy), .frame_done(frame_done));

  // Source buffer with 2-cycle latency: address registered once, data valid
  // on the second cycle the address is held.
  logic [PW-1:0]  src_mem [NPIX];
  logic [ADW-1:0] addr_r;
  always @(posedge clk) addr_r <= src_addr;
  assign pixel_in = (addr_r < ADW'(NPIX)) ? src_mem[addr_r[4:0]] : '0;

  typedef struct { logic [ADW-1:0] a; logic [PW-1:0] p; } wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_err = 0, wr_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Closed-form reference for one destination pixel.
  function automatic logic [PW-1:0] ref_pix(int x, int y);
    logic signed [AW-1:0] xs, ys, nx, ny, d, qx, qy;
    int m, cx, cy;
    bit inr;
    xs = x; ys = y;
    nx = p3 + xs * p1 + ys * p2;
    ny = p6 + xs * p4 + ys * p5;
    d  = p9 + xs * p7 + ys * p8;
    m  = (oob_mode == 2'd3) ? 0 : int'(oob_mode);
    if (d == 0) begin
      qx = 0; qy = 0; inr = 0;
    end else begin
      qx = nx / d; qy = ny / d;
      inr = (qx >= 0) && (qx < H) && (qy >= 0) && (qy < V);
    end
    if (inr || m == 2) begin
      cx = (qx < 0) ? 0 : (qx > H - 1) ? H - 1 : int'(qx);
      cy = (qy < 0) ? 0 : (qy > V - 1) ? V - 1 : int'(qy);
      return src_mem[cy * H + cx];
    end
    return (m == 1) ? border_pix : '0;
  endfunction

  function automatic logic signed [AW-1:0] srnd(int r);
    int v;
    v = int'($urandom_range(0, 2 * r)) - r;
    return AW'(v);
  endfunction

  task automatic set_cf(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
    p1 = AW'(a1); p2 = AW'(a2); p3 = AW'(a3); p4 = AW'(a4); p5 = AW'(a5);
    p6 = AW'(a6); p7 = AW'(a7); p8 = AW'(a8); p9 = AW'(a9);
  endtask

  task automatic scramble();
    p1 = srnd(900); p2 = srnd(900); p3 = srnd(900); p4 = srnd(900); p5 = srnd(900);
    p6 = srnd(900); p7 = srnd(900); p8 = srnd(900); p9 = srnd(900);
    oob_mode = 2'($urandom); border_pix = PW'($urandom);
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (dst_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("spurious_wr", 1, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("dst_addr", dst_addr, e.a);
        chk("pixel_out", pixel_out, e.p);
      end
    end
  end

  task automatic run_frame(input string nm, input int abort_at);
    bit done, aborted;
    exp_q.delete(); wr_cnt = 0; done_cnt = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back('{a: ADW'(y * H + x), p: ref_pix(x, y)});
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    scramble();
    done = 0; aborted = 0;
    for (int cyc = 0; cyc < 20000 && !done && !aborted; cyc++) begin
      @(negedge clk);
      frame_start = (cyc == 50);   // must be ignored while busy
      if (abort_at >= 0 && wr_cnt >= abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_wr"}, dst_wr, 0);
        chk({nm, "_rst_pix"}, pixel_out, 0);
        exp_q.delete();
        aborted = 1;
      end else if (frame_done) done = 1;
    end
    frame_start = 1'b0;
    if (abort_at < 0) begin
      chk({nm, "_finished"}, done, 1);
      if (done) begin
        @(negedge clk);
        chk({nm, "_writes"}, wr_cnt, NPIX);
        chk({nm, "_left"}, exp_q.size(), 0);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_done_pulse"}, frame_done, 0);
      end
    end else begin
      chk({nm, "_aborted"}, aborted, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) src_mem[i] = PW'($urandom);
    set_cf(0, 0, 0, 0, 0, 0, 0, 0, 0);
    oob_mode = 2'd0; border_pix = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr", dst_wr, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pix", pixel_out, 0);
    chk("rst_dst", dst_addr, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_wr", wr_cnt, 0);

    set_cf(1, 0, 0, 0, 1, 0, 0, 0, 1); oob_mode = 2'd0;
    run_frame("ident", -1);
    set_cf(1, 0, -100, 0, 1, 0, 0, 0, 1); oob_mode = 2'd1; border_pix = 12'hF00;
    run_frame("border", -1);
    set_cf(1, 0, -100, 0, 1, 0, 0, 0, 1); oob_mode = 2'd0;
    run_frame("black", -1);
    set_cf(1, 0, 1000, 0, 1, 0, 0, 0, 1); oob_mode = 2'd2;
    run_frame("clampx", -1);
    set_cf(0, 0, 0, 0, 0, 0, 0, 0, 0); oob_mode = 2'd2;
    run_frame("den0", -1);
    set_cf(1, 0, -100, 0, 1, 0, 0, 0, 1); oob_mode = 2'd3; border_pix = 12'hABC;
    run_frame("mode3", -1);

    set_cf(1, 0, 0, 0, 1, 0, 0, 0, 1); oob_mode = 2'd0;
    run_frame("abort", 13);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    repeat (100) @(negedge clk);
    chk("post_rst_no_wr", wr_cnt, 0);
    chk("post_rst_idle", busy, 0);
    set_cf(1, 0, 0, 0, 1, 0, 0, 0, 1); oob_mode = 2'd0;
    run_frame("after_abort", -1);

    for (int f = 0; f < 4; f++) begin
      p1 = srnd(3); p2 = srnd(3); p3 = srnd(15) + AW'(5);
      p4 = srnd(3); p5 = srnd(3); p6 = srnd(10) + AW'(2);
      p7 = srnd(1); p8 = srnd(1); p9 = srnd(3);
      oob_mode = 2'($urandom); border_pix = PW'($urandom);
      run_frame($sformatf("rand%0d", f), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_map_param.md
PIXEL_MAP_PARAM -- requirements
Module: pixel_map_param

Interface
REQ-001 Parameter H_ACTIVE, default 640: output frame width in pixels.
REQ-002 Parameter V_ACTIVE, default 480: output frame height in pixels.
REQ-003 Parameter PIX_W, default 12: pixel data width.
REQ-004 Parameter ACC_W, default 79: signed width of all coefficients, accumulators and divider operands.
REQ-005 Parameter ADDR_W, default 17: buffer address width.
REQ-006 Parameter SCALE_SH, default 1: buffer subsampling shift applied to x and y before address formation.
REQ-007 Parameter MEM_LAT, default 1: source-buffer read latency in cycles, range 1..7.
REQ-008 Port list; one clock, asynchronous active-low reset; all other inputs are sampled on the rising edge of clk:
  clk  in  1  system clock.
  rst_n  in  1  asynchronous active-low reset.
  frame_start  in  1  one-cycle request to map one frame.
  p1..p9  in  ACC_W each, signed  inverse-perspective coefficients.
  oob_mode  in  2  out-of-range policy: 0 black, 1 border colour, 2 clamp, 3 treated as 0.
  border_pix  in  PIX_W  colour used when oob_mode=1.
  pixel_in  in  PIX_W  source-buffer read data.
  src_addr  out  ADDR_W  source-buffer read address.
  pixel_out  out  PIX_W  destination write data.
  dst_addr  out  ADDR_W  destination write address.
  dst_wr  out  1  destination write strobe.
  busy  out  1  frame in progress.
  frame_done  out  1  one-cycle pulse after the last write.

Function
REQ-009 States: IDLE, DIV, MEMW, WR, NEXT; the block SHALL leave IDLE only on frame_start=1.
REQ-010 In IDLE, frame_start SHALL latch p1..p9, oob_mode and border_pix into shadow registers, set x=y=0, set num_x=row_x=p3, num_y=row_y=p6, den=row_d=p9, and set busy=1; later input changes SHALL NOT affect the frame.
REQ-011 frame_start while busy=1 SHALL be ignored.
REQ-012 DIV: two signed ACC_W-wide divisions, num_x/den and num_y/den, SHALL start together; the block SHALL wait until both are ready; quotients are qx and qy.
REQ-013 If den==0, the block SHALL NOT start the divisions, SHALL treat the pixel as out of range, and in clamp mode SHALL use qx=qy=0.
REQ-014 Range check: a pixel is in range iff 0<=qx<=H_ACTIVE-1 and 0<=qy<=V_ACTIVE-1.
REQ-015 Clamp mode SHALL saturate qx to [0,H_ACTIVE-1] and qy to [0,V_ACTIVE-1]; a clamped pixel SHALL read the source like an in-range pixel.
REQ-016 Address: addr(a,b)=(b>>SCALE_SH)*(H_ACTIVE>>SCALE_SH)+(a>>SCALE_SH), truncated to ADDR_W; src_addr=addr(qx,qy) and dst_addr=addr(x,y).
REQ-017 MEMW: src_addr SHALL hold for exactly MEM_LAT cycles, then pixel_in SHALL be sampled; out-of-range pixels in modes 0 and 1 SHALL skip MEMW.
REQ-018 WR: dst_wr=1 for exactly one cycle with pixel_out = sampled pixel, 0 (black), or border_pix, as selected by the range check and oob_mode.
REQ-019 NEXT, when x<H_ACTIVE-1: x+=1, num_x+=p1, num_y+=p4, den+=p7.
REQ-020 NEXT, when x==H_ACTIVE-1 and y<V_ACTIVE-1: x=0, y+=1; row_x+=p2, row_y+=p5, row_d+=p8; num_x, num_y and den SHALL load the updated row values (exact; no end-of-row subtraction).
REQ-021 NEXT, when x==H_ACTIVE-1 and y==V_ACTIVE-1: go to IDLE with busy=0 and frame_done=1 for one cycle.
REQ-022 All accumulator arithmetic SHALL be ACC_W-bit two's complement with wrap-around on overflow.
REQ-023 Exactly H_ACTIVE*V_ACTIVE writes SHALL occur per frame, in raster order, one per pixel.

Reset
REQ-024 rst_n=0 SHALL, asynchronously, force IDLE, busy=0, frame_done=0, dst_wr=0, pixel_out=0, x=y=0, all accumulators and shadow registers to 0, and abort any division.
REQ-025 After deassertion, no write SHALL occur until a new frame_start.

Verification
REQ-026 H_ACTIVE=8, V_ACTIVE=4, SCALE_SH=0, p1=p5=p9=1, others 0 -> 32 writes, each pixel_out equals source[dst_addr], frame_done once.
REQ-027 Same size, p3=-100, oob_mode=1, border_pix=12'hF00 -> all 32 writes are 12'hF00 with no MEMW cycles; repeat with oob_mode=0 -> all 12'h000.
REQ-028 p3=1000, p1=1, p5=1, p9=1, oob_mode=2 -> every write reads source x=7 of its row.
REQ-029 p9=0, all other coefficients 0, oob_mode=2 -> no division started, every pixel reads source (0,0).
REQ-030 rst_n pulsed low mid-frame (pixel 13) -> dst_wr=0 and busy=0 immediately; a new frame_start then produces 32 correct writes; frame_start while busy -> ignored.
